// File: rtl/spi_pkg.sv
// spi_pkg: shared SPI master frame constants and FSM state encoding
package spi_pkg;
    localparam int DEF_ADDR_WIDTH = 8;
    localparam int DEF_DATA_WIDTH = 16;
    localparam int FRAME_BITS = 24;
    localparam int RW_BIT = 7;
    localparam logic READ = 1'b1;
    localparam logic WRITE = 1'b0;
    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;
endpackage

// File: rtl/spi_sck_gen.sv
// spi_sck_gen: half-period counter producing SCK rise/fall strobes while enabled
module spi_sck_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic rise,
    output logic fall
);
    logic [7:0] hcnt;
    logic phase;
    logic wrap;
    assign wrap = en && hcnt == 8'(CLK_DIV - 1);
    assign rise = wrap && !phase;
    assign fall = wrap && phase;
    always_ff @(posedge clk) begin
        if (!rst_n || !en) begin
            hcnt <= '0;
            phase <= 1'b0;
        end else begin
            hcnt <= wrap ? '0 : hcnt + 8'd1;
            phase <= phase ^ wrap;
        end
    end
endmodule

// File: rtl/spi_master.sv
// spi_master: mode-0 SPI master sending {rw, addr, wdata} frames and capturing read data
module spi_master #(
    parameter int CLK_DIV = 4,
    parameter int ADDR_WIDTH = spi_pkg::DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = spi_pkg::DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  rw,
    input  logic [ADDR_WIDTH-2:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  spi_cs,
    output logic                  spi_sck,
    output logic                  spi_mosi,
    input  logic                  spi_miso
);
    import spi_pkg::*;
    localparam int FB = ADDR_WIDTH + DATA_WIDTH;
    localparam int BW = $clog2(FB);
    state_t state, state_n;
    logic [8:0] cnt;
    logic [BW-1:0] bits;
    logic [FB-1:0] sr;
    logic [DATA_WIDTH-1:0] rx;
    logic rd, en, rise, fall, cnt_end, last;
    spi_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck (
        .clk(clk),
        .rst_n(rst_n),
        .en(en),
        .rise(rise),
        .fall(fall)
    );
    assign last = bits == BW'(FB - 1);
    assign busy = state != IDLE;
    assign done = state == GAP && cnt == '0;
    assign spi_cs = !(state == SETUP || state == SHIFT || state == HOLD);
    assign spi_mosi = busy && sr[FB-1];
    always_comb begin
        state_n = state;
        en = state == SHIFT;
        cnt_end = cnt == 9'(state == GAP ? 2 * CLK_DIV - 1 : CLK_DIV - 1);
        case (state)
            IDLE:    state_n = start ? SETUP : IDLE;
            SETUP:   state_n = cnt_end ? SHIFT : SETUP;
            SHIFT:   state_n = fall && last ? HOLD : SHIFT;
            HOLD:    state_n = cnt_end ? GAP : HOLD;
            GAP:     state_n = cnt_end ? IDLE : GAP;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt <= '0;
            bits <= '0;
            sr <= '0;
            rx <= '0;
            rd <= 1'b0;
            rdata <= '0;
            spi_sck <= 1'b0;
        end else begin
            state <= state_n;
            cnt <= (state == IDLE || state == SHIFT || cnt_end) ? '0 : cnt + 9'd1;
            bits <= state == IDLE ? '0 : (fall && !last) ? bits + BW'(1) : bits;
            spi_sck <= rise || (spi_sck && !fall);
            if (state == IDLE && start) begin
                sr <= {rw, addr, wdata & {DATA_WIDTH{rw != READ}}};
                rd <= rw == READ;
            end else if (fall) begin
                sr <= {sr[FB-2:0], 1'b0};
            end
            if (fall && bits >= BW'(ADDR_WIDTH))
                rx <= {rx[DATA_WIDTH-2:0], spi_miso};
            if (state == HOLD && cnt_end && rd)
                rdata <= rx;
        end
    end
endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 Parameter CLK_DIV, default 4, SCK half-period in clk cycles; legal range 2..255.
REQ-002 Parameter ADDR_WIDTH, default 8, address-phase length in bits: {rw_flag, addr[6:0]}.
REQ-003 Parameter DATA_WIDTH, default 16, data-phase length in bits.
REQ-004 clk  input  1  system clock; the single clock domain for all logic.
REQ-005 rst_n  input  1  reset, synchronous to clk and active-low.
REQ-006 start  input  1  transaction request; sampled only when busy=0.
REQ-007 rw  input  1  1 = read, 0 = write; sent as the address-byte MSB.
REQ-008 addr  input  7  register address; sent as address-byte bits [6:0].
REQ-009 wdata  input  16  write data, sent MSB first.
REQ-010 busy  output  1  high from the cycle after start is accepted until the transaction completes.
REQ-011 done  output  1  one-cycle pulse at the end of the transaction.
REQ-012 rdata  output  16  read data; valid when done is high.
REQ-013 spi_cs  output  1  chip select, active-low.
REQ-014 spi_sck  output  1  SPI clock, mode 0 (CPOL=0, CPHA=0).
REQ-015 spi_mosi  output  1  serial data to the slave.
REQ-016 spi_miso  input  1  serial data from the slave; spi_miso is treated as already synchronous to clk.

Function
REQ-017 The FSM shall have the states IDLE, SETUP, SHIFT, HOLD and GAP.
REQ-018 In IDLE with start=1, the block shall latch rw, addr and wdata into a 24-bit shift register {rw, addr, wdata} and enter SETUP.
REQ-019 In the cycle after acceptance: busy=1, spi_cs=0, spi_sck=0, and spi_mosi = shift register bit 23.
REQ-020 SETUP shall last CLK_DIV cycles and then enter SHIFT.
REQ-021 SHIFT shall produce exactly 24 SCK periods.
  - Each period is CLK_DIV cycles with SCK low, then CLK_DIV cycles with SCK high.
  - A half-period counter generates the edges.
REQ-022 spi_miso shall be sampled in the clk cycle in which spi_sck is driven from 1 to 0.
REQ-023 On each SCK falling edge, spi_mosi shall advance to the next bit, MSB first.
  - spi_mosi shall be 0 in IDLE and in the data phase of a read.
REQ-024 The bit counter shall run 0..23.
  - After the 24th falling edge: SCK stays low, the counter does not wrap, and the FSM enters HOLD.
REQ-025 MISO samples for bits 8..23 shall shift MSB first into an internal register.
  - MISO during bits 0..7 shall be ignored.
REQ-026 HOLD shall last CLK_DIV cycles and then enter GAP.
  - On the HOLD→GAP transition: spi_cs=1, done=1 for one cycle.
  - For a read, rdata is updated in that same cycle.
  - For a write, rdata keeps its previous value.
REQ-027 GAP shall last 2*CLK_DIV cycles with spi_cs=1, then return to IDLE with busy=0.
REQ-028 busy shall stay high for exactly 52*CLK_DIV cycles per transaction (208 at the default).
REQ-029 start while busy=1, including during GAP and the done cycle, shall be ignored and not queued.
REQ-030 start in the first cycle with busy=0 shall be accepted.
REQ-031 Changes to rw, addr or wdata after acceptance shall not affect the transaction in progress.

Reset
REQ-032 With rst_n=0 at a clk edge, the following shall hold from the next cycle, regardless of FSM state:
  - spi_cs=1, spi_sck=0, spi_mosi=0
  - busy=0, done=0, rdata=16'h0000
  - state=IDLE, all counters 0
REQ-033 Reset during a transaction shall abort it with no done pulse.
  - The next start after release shall execute a complete, correct transaction.

Structure
REQ-034 Shared package spi_pkg shall hold:
  - the ADDR_WIDTH and DATA_WIDTH defaults
  - RW_BIT=7, with READ=1 and WRITE=0
  - the FSM state encoding
  - FRAME_BITS=24
REQ-035 One sub-module, spi_sck_gen, shall provide the half-period counter and rise/fall strobes.
  - It is enabled by the FSM and cleared by rst_n.

Verification
REQ-036 Write scenario: CLK_DIV=4, write addr 0x02, wdata 0x1234 → required response:
  - MOSI bits captured on SCK rises = 0x02, 0x12, 0x34
  - 24 SCK rises
  - done pulse once; busy high 208 cycles
REQ-037 Read scenario: read addr 0x01, slave model returns 0xAA33 → required response:
  - address byte on MOSI = 0x81
  - data-phase MOSI all 0
  - rdata=0xAA33 in the done cycle
REQ-038 Back-to-back read scenario: read addr 0x00, slave returns 0x0AD0, then immediately a read of addr 0x01 → required response:
  - rdata=0x0AD0, then 0xAA33
  - spi_cs high ≥8 cycles between frames
REQ-039 Start-while-busy scenario: start pulsed at cycles 10, 100 and 205 of a transaction → all ignored, one done only; start at the first busy=0 cycle is accepted.
REQ-040 Reset-abort scenario: rst_n low for 1 cycle during SHIFT bit 10 → required response:
  - next cycle spi_cs=1, spi_sck=0, busy=0, no done
  - a following write of 0x55AA to addr 0x02 is correct
REQ-041 Minimum-divider scenario: CLK_DIV=2 with a MISO loopback of the slave model → busy 104 cycles and the bit-exact rdata expected from the model.
